// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed wait latency
//
// Purpose: word-addressed 32-bit data memory that accepts one load or store
// request at a time, waits LATENCY cycles and then presents one response
// that is held until the requester consumes it.
//
// Parameters:
//   DEPTH   - number of 32-bit words of storage (power of two, >= 4)
//   LATENCY - wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request presented
//   req_ready  out  request accepted this cycle (only in IDLE)
//   req_wr     in   1 = store word, 0 = load word
//   req_adr    in   byte address [31:0]
//   req_wdata  in   store data [31:0]
//   rsp_valid  out  response presented
//   rsp_ready  in   response consumed
//   rsp_rdata  out  load data [31:0], 0 for stores and errors
//   rsp_err    out  misaligned or out-of-range request

module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        lat_wr;
    logic [31:0] lat_adr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        cur_wr;
    logic [31:0] cur_adr;
    logic [31:0] cur_wdata;
    logic        cur_err;
    logic [AW-1:0] cur_idx;

    // Upper address bits must be zero so out-of-range words never alias
    // onto real storage.
    function automatic logic adr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    state_nxt = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero latency the response is formed on the accept edge itself,
    // so the live request is used instead of the (not yet loaded) latches.
    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign cur_wr     = (state == IDLE) ? req_wr    : lat_wr;
    assign cur_adr    = (state == IDLE) ? req_adr   : lat_adr;
    assign cur_wdata  = (state == IDLE) ? req_wdata : lat_wdata;
    assign cur_err    = adr_err(cur_adr);
    assign cur_idx    = cur_adr[AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            lat_wr    <= 1'b0;
            lat_adr   <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            if (accept) begin
                cnt       <= CNT_INIT;
                lat_wr    <= req_wr;
                lat_adr   <= req_adr;
                lat_wdata <= req_wdata;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= cur_err;
            rsp_rdata <= (!cur_wr && !cur_err) ? mem[cur_idx] : 32'd0;
        end
    end

    // Storage is not reset; rst_n only blocks a commit while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cur_wr && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed-vector bench for dmem_responder (LATENCY 2 and 0)

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_adr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [31:0] rsp_rdata_m;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut_l2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid & ~sel),
        .req_ready (req_ready0),
        .req_wr    (req_wr),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) dut_l0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid & sel),
        .req_ready (req_ready1),
        .req_wr    (req_wr),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid1),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata1),
        .rsp_err   (rsp_err1)
    );

    assign req_ready_m = sel ? req_ready1 : req_ready0;
    assign rsp_valid_m = sel ? rsp_valid1 : rsp_valid0;
    assign rsp_err_m   = sel ? rsp_err1   : rsp_err0;
    assign rsp_rdata_m = sel ? rsp_rdata1 : rsp_rdata0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete request/response; latency counts rising edges from the
    // accept edge (inclusive) until rsp_valid is seen.
    task automatic txn(input string tag, input logic wr, input logic [31:0] adr,
                       input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_adr   = adr;
        req_wdata = wd;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'd0, req_ready_m}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, rsp_valid_m ? n : -1, exp_lat);
        check({tag, "_rdata"}, rsp_rdata_m, exp_rd);
        check({tag, "_err"}, {31'd0, rsp_err_m}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_done"}, {31'd0, rsp_valid_m}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        sel       = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_adr   = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready_m}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid_m}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata_m, 32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err_m}, 32'd0);
        rst_n = 1'b1;

        // LATENCY=2: response visible 3 edges after acceptance
        txn("st_10",   1'b1, 32'h10,  32'hDEADBEEF, 3, 32'h0,        1'b0);
        txn("ld_10",   1'b0, 32'h10,  32'h0,        3, 32'hDEADBEEF, 1'b0);
        txn("st_11",   1'b1, 32'h11,  32'h12345678, 3, 32'h0,        1'b1);
        txn("ld_10b",  1'b0, 32'h10,  32'h0,        3, 32'hDEADBEEF, 1'b0);
        txn("ld_400",  1'b0, 32'h400, 32'h0,        3, 32'h0,        1'b1);
        txn("st_0",    1'b1, 32'h0,   32'h11111111, 3, 32'h0,        1'b0);
        txn("st_400",  1'b1, 32'h400, 32'h22222222, 3, 32'h0,        1'b1);
        txn("ld_0",    1'b0, 32'h0,   32'h0,        3, 32'h11111111, 1'b0);
        txn("st_3fc",  1'b1, 32'h3FC, 32'hA5A55A5A, 3, 32'h0,        1'b0);
        txn("ld_3fc",  1'b0, 32'h3FC, 32'h0,        3, 32'hA5A55A5A, 1'b0);
        txn("ld_hi",   1'b0, 32'h8000_0010, 32'h0,  3, 32'h0,        1'b1);
        txn("st_20z",  1'b1, 32'h20,  32'h0,        3, 32'h0,        1'b0);

        // Backpressure: request held valid throughout, response stalled 5 cycles
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_adr   = 32'h10;
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid0", {31'd0, rsp_valid_m}, 32'd1);
        held = rsp_rdata_m;
        check("bp_rdata0", held, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid_m}, 32'd1);
            check("bp_rdata", rsp_rdata_m, 32'hDEADBEEF);
            check("bp_req_ready", {31'd0, req_ready_m}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("bp_one_rsp", {31'd0, rsp_valid_m}, 32'd0);
        repeat (4) @(negedge clk);
        check("bp_no_second", {31'd0, rsp_valid_m}, 32'd0);

        // Reset during WAIT of a store: store lost, outputs return to reset values
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_adr   = 32'h20;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mr_in_wait", {31'd0, req_ready_m}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mr_req_ready", {31'd0, req_ready_m}, 32'd1);
        check("mr_rsp_valid", {31'd0, rsp_valid_m}, 32'd0);
        check("mr_rsp_rdata", rsp_rdata_m, 32'd0);
        check("mr_rsp_err",   {31'd0, rsp_err_m}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("mr_no_rsp", {31'd0, rsp_valid_m}, 32'd0);
        end
        txn("mr_ld_20", 1'b0, 32'h20, 32'h0, 3, 32'h0, 1'b0);

        // LATENCY=0 instance
        sel = 1'b1;
        txn("z_st_0", 1'b1, 32'h0, 32'h00000001, 1, 32'h0,        1'b0);
        txn("z_ld_0", 1'b0, 32'h0, 32'h0,        1, 32'h00000001, 1'b0);
        txn("z_st_13", 1'b1, 32'h13, 32'hFFFFFFFF, 1, 32'h0,      1'b1);
        txn("z_ld_0b", 1'b0, 32'h0, 32'h0,       1, 32'h00000001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words of storage (power of two, at least 4).
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning the wait cycles between request acceptance and response (0 to 15).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is an asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  means the CPU side presents a request.
REQ-006 Port req_ready  output  1  means the responder accepts a request this cycle.
REQ-007 Port req_wr  input  1  selects the operation: 1 = store word, 0 = load word.
REQ-008 Port req_adr  input  32  is the byte address.
REQ-009 Port req_wdata  input  32  is the store data.
REQ-010 Port rsp_valid  output  1  means a response is presented.
REQ-011 Port rsp_ready  input  1  means the CPU side consumes the response.
REQ-012 Port rsp_rdata  output  32  is the load data; it is 0 for stores and for errors.
REQ-013 Port rsp_err  output  1  flags a misaligned or out-of-range request.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, WAIT and RESP, encoded in 2 bits.
REQ-015 In IDLE, req_ready SHALL be 1, and every other state SHALL drive req_ready to 0.
REQ-016 The request SHALL be accepted when req_valid and req_ready are both 1 on a clock edge.
- On acceptance, req_wr, req_adr and req_wdata SHALL be latched.
REQ-017 On acceptance, the next state SHALL be WAIT if LATENCY>0, otherwise RESP.
- The wait counter SHALL load LATENCY-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle.
- When the counter is 0, the next state SHALL be RESP.
- A response therefore appears exactly LATENCY+1 cycles after the acceptance edge.
REQ-019 The error condition SHALL be evaluated on the latched address: err = (adr[1:0] != 0) OR (adr[31:2] >= DEPTH).
REQ-020 A store without err SHALL write mem[adr[31:2]] with the latched wdata on the edge leaving WAIT, or on the accept edge when LATENCY=0.
- A store with err SHALL NOT modify memory.
REQ-021 A load without err SHALL register mem[adr[31:2]] into rsp_rdata on entry to RESP.
REQ-022 In RESP, rsp_valid SHALL be 1, and rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
- On that edge the next state SHALL be IDLE.
REQ-023 Back-to-back operation: the minimum request-to-request spacing SHALL be LATENCY+2 cycles.
- There is no request overlap or pipelining.
REQ-024 The responder SHALL ignore req_valid outside IDLE; the requester holds its request until req_ready.
REQ-025 A store followed by a load to the same word SHALL return the stored data, with no stale read.
REQ-026 Address bits above the storage range SHALL NOT alias; they produce err.

Reset
REQ-027 While rst_n=0, the following outputs SHALL be forced:
- state = IDLE
- counter = 0
- req_ready = 1
- rsp_valid = 0
- rsp_rdata = 0
- rsp_err = 0
REQ-028 Reset asserted mid-transaction SHALL abort it.
- A pending store not yet committed per REQ-020 SHALL be lost.
- No response SHALL be produced after release.
REQ-029 Memory contents SHALL NOT be affected by reset.
REQ-030 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-031 Store then load, LATENCY=2:
- Stimulus: store 0xDEADBEEF to adr 0x10, then load adr 0x10.
- Response: each rsp_valid rises 3 cycles after acceptance; the load returns 0xDEADBEEF with err=0.
REQ-032 Misaligned store:
- Stimulus: store 0x12345678 to adr 0x11, then load adr 0x10 (previously 0xDEADBEEF).
- Response: the store responds with err=1; the load returns 0xDEADBEEF.
REQ-033 Out-of-range load, DEPTH=256:
- Stimulus: load adr 0x400.
- Response: rsp_err=1 and rsp_rdata=0.
REQ-034 Response backpressure:
- Stimulus: hold rsp_ready=0 for 5 cycles with req_valid=1 continuously.
- Response: rsp_valid and rsp_rdata stay stable, req_ready stays 0, and exactly one response completes when rsp_ready rises.
REQ-035 Reset mid-transaction:
- Stimulus: assert rst_n=0 during WAIT of a store of 0xCAFEF00D to adr 0x20 (previously 0); release, then load adr 0x20.
- Response: outputs reach reset values immediately; the load returns 0.
REQ-036 Zero latency, LATENCY=0:
- Stimulus: store then load adr 0x0 with data 0x00000001.
- Response: rsp_valid 1 cycle after each acceptance; the load returns 0x00000001.
